// File: rtl/spi_reg_bridge_pkg.sv
// Shared opcodes and FSM state encoding for the SPI-to-register-bus bridge.
package spi_reg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    WDATA,
    RDATA,
    DISCARD
  } state_t;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte stream from spi_slave plus the register bus driven by spi_reg_bridge.
interface spi_reg_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                  frame_active;
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic [7:0]            tx_byte;
  logic                  tx_load;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  frame_err;

  modport slave (
    input  frame_active, rx_valid, rx_byte, rd_data,
    output tx_byte, tx_load, wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err
  );

  modport master (
    output frame_active, rx_valid, rx_byte, rd_data,
    input  tx_byte, tx_load, wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err
  );

endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes framed SPI commands (CMD, ADDR_HI, ADDR_LO, data words) into register
// writes and reads, auto-incrementing the word address and feeding MISO bytes on reads.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  spi_reg_bridge_if.slave bus
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  state_t                state_q, state_d;
  logic                  fa_q;
  logic                  is_write_q, is_write_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  rd_cap_q;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_load_q, tx_load_d;
  logic                  frame_err_q, frame_err_d;

  logic                  frame_rise;
  logic                  byte_ok;
  logic [15:0]           addr_full;
  logic [ADDR_WIDTH-1:0] addr_next;

  // A byte arriving on the very cycle SSEL drops still belongs to the frame.
  assign frame_rise = bus.frame_active & ~fa_q;
  assign byte_ok    = bus.rx_valid & (bus.frame_active | fa_q);
  assign addr_full  = {addr_hi_q, bus.rx_byte};
  assign addr_next  = addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    tx_byte_d   = tx_byte_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_rise) begin
          state_d = CMD;
          bcnt_d  = '0;
        end
      end
      CMD: begin
        if (byte_ok) begin
          if (bus.rx_byte == OP_WRITE) begin
            is_write_d = 1'b1;
            state_d    = ADDR_HI;
          end else if (bus.rx_byte == OP_READ) begin
            is_write_d = 1'b0;
            state_d    = ADDR_HI;
          end else begin
            frame_err_d = 1'b1;
            state_d     = DISCARD;
          end
        end
      end
      ADDR_HI: begin
        if (byte_ok) begin
          addr_hi_d = bus.rx_byte;
          state_d   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (byte_ok) begin
          addr_d = addr_full[ADDR_WIDTH-1:0];
          bcnt_d = '0;
          if (is_write_q) begin
            state_d = WDATA;
          end else begin
            state_d   = RDATA;
            rd_en_d   = bus.frame_active;
            rd_addr_d = addr_full[ADDR_WIDTH-1:0];
          end
        end
      end
      WDATA: begin
        if (byte_ok) begin
          shift_d = (shift_q << 8) | DATA_WIDTH'(bus.rx_byte);
          if (bcnt_q == LAST_BYTE) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shift_d;
            addr_d    = addr_next;
            bcnt_d    = '0;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      RDATA: begin
        // bcnt tracks which byte of word_q is currently parked on MISO.
        if (rd_cap_q) begin
          word_d    = bus.rd_data;
          tx_byte_d = bus.rd_data[DATA_WIDTH-1 -: 8];
          tx_load_d = 1'b1;
          bcnt_d    = '0;
        end else if (byte_ok) begin
          if (bcnt_q == LAST_BYTE) begin
            addr_d    = addr_next;
            bcnt_d    = '0;
            rd_en_d   = bus.frame_active;
            rd_addr_d = addr_next;
          end else begin
            word_d    = word_q << 8;
            tx_byte_d = word_d[DATA_WIDTH-1 -: 8];
            tx_load_d = 1'b1;
            bcnt_d    = bcnt_q + BCW'(1);
          end
        end
      end
      DISCARD: begin
      end
      default: state_d = IDLE;
    endcase

    // Frame end wins over everything except a write completed by the last byte.
    if (state_q != IDLE && !bus.frame_active) begin
      state_d   = IDLE;
      tx_byte_d = 8'h00;
      tx_load_d = 1'b0;
      if (state_q == WDATA && bcnt_d != '0) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fa_q        <= 1'b0;
      is_write_q  <= 1'b0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      rd_cap_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tx_byte_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fa_q        <= bus.frame_active;
      is_write_q  <= is_write_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      rd_cap_q    <= rd_en_q;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      tx_byte_q   <= tx_byte_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.frame_err = frame_err_q;

endmodule
